ram_writer: RTL

- Write-side counterpart to the team's behavioural ROMs: a stream-loaded 32x32 synchronous RAM.
- Accepts a valid/ready word stream, writes words to consecutive addresses from 0, and reports completion.
- Its read port uses the same clock/reset/addr/y convention as the ROMs, so benches can swap it in for a ROM and read back what was loaded.

---
 rtl/ram_writer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ram_writer.sv
// Stream-loaded synchronous RAM: valid/ready words are written to consecutive addresses from 0,
// and a ROM-style registered read port (addr -> y, one-cycle latency) reads them back.
module ram_writer #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          done,
  output logic          full,
  output logic [AW:0]   count,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] y
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } state_e;

  localparam logic [AW:0] LastSlot = (AW + 1)'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic [DW-1:0] y_q, y_d;
  logic          mem_we;

  logic [DW-1:0] mem_q [DEPTH];

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    count_d  = count_q;
    full_d   = full_q;
    mem_we   = 1'b0;
    in_ready = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          wptr_d  = '0;
          count_d = '0;
          full_d  = 1'b0;
        end
      end

      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we  = 1'b1;
          wptr_d  = wptr_q + AW'(1);
          count_d = count_q + (AW + 1)'(1);
          if (in_last) begin
            state_d = StDone;
          end else if (count_q == LastSlot) begin
            // Memory filled before the stream ended; pointer wraps but nothing more is written.
            state_d = StDone;
            full_d  = 1'b1;
          end
        end
      end

      StDone: begin
        done = 1'b1;
        if (start) begin
          state_d = StLoad;
          wptr_d  = '0;
          count_d = '0;
          full_d  = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Contents survive reset; only the control state is cleared.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem_q[wptr_q] <= in_data;
    end
  end

  // Read-first: a same-edge write to addr is not visible until the following read.
  always_comb begin
    y_d = mem_q[addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign count = count_q;
  assign full  = full_q;
  assign y     = y_q;

endmodule
